// File: rtl/map_uxrom_gen_pkg.sv
// Shared mapper bus types and register-map constants for the UxROM-style mapper family.
package map_uxrom_gen_pkg;

  typedef struct packed {
    logic        m2;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
  } cpu_bus_t;

  // we is an active-low PPU write strobe
  typedef struct packed {
    logic [13:0] addr;
    logic        rd;
    logic        we;
  } ppu_bus_t;

  typedef struct packed {
    logic       chr_ram;
    logic       mir_v;
    logic [7:0] map_idx;
  } map_cfg_t;

  typedef struct packed {
    logic       act;
    logic       we_reg;
    logic [7:0] addr;
    logic [7:0] dato;
  } sst_bus_t;

  typedef struct packed {
    cpu_bus_t   cpu;
    ppu_bus_t   ppu;
    map_cfg_t   cfg;
    sst_bus_t   sst;
    logic [7:0] prg_do;
    logic [7:0] chr_do;
    logic [7:0] srm_do;
  } map_in_t;

  typedef struct packed {
    logic [21:0] addr;
    logic        ce;
    logic        oe;
    logic        we;
  } mem_ctl_t;

  typedef struct packed {
    mem_ctl_t   prg;
    mem_ctl_t   chr;
    mem_ctl_t   srm;
    logic       ciram_a10;
    logic       ciram_ce;
    logic [7:0] data;
    logic       oe;
    logic [7:0] sst_di;
    logic       irq;
    logic       bus_cf;
    logic       mask_off;
    logic       mir_4sc;
  } map_out_t;

  localparam logic [7:0] SstAddrPrg    = 8'd0;
  localparam logic [7:0] SstAddrChr    = 8'd1;
  localparam logic [7:0] SstAddrMapIdx = 8'd127;

  localparam int unsigned ChrLsb = 5;
  localparam int unsigned MirBit = 7;

  function automatic logic [4:0] field_mask(input int unsigned bits);
    return 5'((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/m2_edge_sync.sv
// Two-flop synchroniser for CPU M2 with a one-clock falling-edge strobe.
module m2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic m2_sync,
  output logic m2_fall
);

  logic       meta_q, sync_q, prev_q;
  logic [1:0] arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      arm_q  <= 2'd0;
    end else begin
      meta_q <= m2;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (arm_q != 2'd2) arm_q <= arm_q + 2'd1;
    end
  end

  // Strobe stays masked until the pipeline has refilled after reset.
  assign m2_sync = sync_q;
  assign m2_fall = prev_q & ~sync_q & (arm_q == 2'd2);

endmodule

// File: rtl/map_uxrom_gen.sv
// Generic UxROM mapper: one switchable 16 KB PRG window, optional CHR bank and one-screen mirroring.
module map_uxrom_gen
  import map_uxrom_gen_pkg::*;
#(
  parameter int unsigned PRG_BITS  = 3,
  parameter int unsigned PRG_SHIFT = 2,
  parameter int unsigned FIXED_LOW = 0,
  parameter int unsigned CHR_BITS  = 0,
  parameter int unsigned MIR1_EN   = 0,
  parameter int unsigned BUS_CF    = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  map_in_t  mai,
  output map_out_t mao
);

  localparam logic [4:0] PrgMask  = field_mask(PRG_BITS);
  localparam logic [1:0] ChrMask  = 2'(field_mask(CHR_BITS));
  localparam logic       MirEn    = (MIR1_EN != 0);
  localparam logic       FixedLow = (FIXED_LOW != 0);
  localparam logic       BusCf    = (BUS_CF != 0);

  logic m2_sync, m2_fall;

  m2_edge_sync u_m2_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .m2      (mai.cpu.m2),
    .m2_sync (m2_sync),
    .m2_fall (m2_fall)
  );

  logic       cap_a15_q, cap_rw_q;
  logic [7:0] cap_data_q, cap_prg_do_q;
  logic [4:0] prg_q, prg_d;
  logic [1:0] chr_q, chr_d;
  logic       mir_q, mir_d;

  logic [7:0] latched;
  logic       cpu_commit, sst_wr;
  logic [4:0] bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a15_q    <= 1'b0;
      cap_rw_q     <= 1'b0;
      cap_data_q   <= 8'h00;
      cap_prg_do_q <= 8'h00;
      prg_q        <= 5'd0;
      chr_q        <= 2'd0;
      mir_q        <= 1'b0;
    end else begin
      if (m2_sync) begin
        cap_a15_q    <= mai.cpu.addr[15];
        cap_rw_q     <= mai.cpu.rw;
        cap_data_q   <= mai.cpu.data;
        cap_prg_do_q <= mai.prg_do;
      end
      prg_q <= prg_d;
      chr_q <= chr_d;
      mir_q <= mir_d;
    end
  end

  // Bus conflict: ROM drives the same bus, so the mapper sees the wired-AND.
  assign latched    = BusCf ? (cap_data_q & cap_prg_do_q) : cap_data_q;
  assign cpu_commit = m2_fall & cap_a15_q & ~cap_rw_q & ~mai.sst.act;
  assign sst_wr     = mai.sst.act & mai.sst.we_reg;

  always_comb begin
    prg_d = prg_q;
    chr_d = chr_q;
    mir_d = mir_q;
    if (sst_wr) begin
      if (mai.sst.addr == SstAddrPrg) begin
        prg_d = mai.sst.dato[4:0] & PrgMask;
      end else if (mai.sst.addr == SstAddrChr) begin
        chr_d = mai.sst.dato[ChrLsb +: 2] & ChrMask;
        mir_d = mai.sst.dato[MirBit] & MirEn;
      end
    end else if (cpu_commit) begin
      prg_d = 5'(latched >> PRG_SHIFT) & PrgMask;
      chr_d = latched[ChrLsb +: 2] & ChrMask;
      mir_d = latched[MirBit] & MirEn;
    end
  end

  always_comb begin
    if (mai.cpu.addr[14]) bank = FixedLow ? prg_q : PrgMask;
    else                  bank = FixedLow ? 5'd0 : prg_q;
  end

  always_comb begin
    mao = '0;
    mao.prg.addr  = {3'b000, bank, mai.cpu.addr[13:0]};
    mao.prg.ce    = mai.cpu.addr[15];
    mao.prg.oe    = mai.cpu.rw;
    mao.chr.addr  = {7'd0, chr_q, mai.ppu.addr[12:0]};
    mao.chr.ce    = ~mai.ppu.addr[13];
    mao.chr.oe    = mai.ppu.rd;
    mao.chr.we    = mai.cfg.chr_ram & ~mai.ppu.we;
    mao.ciram_ce  = mai.ppu.addr[13];
    mao.ciram_a10 = MirEn ? mir_q
                          : (mai.cfg.mir_v ? mai.ppu.addr[10] : mai.ppu.addr[11]);
    case (mai.sst.addr)
      SstAddrPrg:    mao.sst_di = {3'b000, prg_q};
      SstAddrChr:    mao.sst_di = {mir_q, chr_q, 5'd0};
      SstAddrMapIdx: mao.sst_di = mai.cfg.map_idx;
      default:       mao.sst_di = 8'hff;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{mai.chr_do, mai.srm_do};

endmodule
